// File: rtl/cdb_arbiter_pkg.sv
// Shared execution-core types: ALU operand/result structs, CDB broadcast struct,
// functional-unit IDs and the CDB arbiter's default sizes.
`ifndef ROB_SIZE
`define ROB_SIZE 6
`endif

package cdb_arbiter_pkg;

  localparam int CDB_NUM_REQ_DEF = 4;
  localparam int CDB_XLEN_DEF    = 32;
  localparam int CDB_TAG_W_DEF   = `ROB_SIZE;

  // Index of each functional-unit result FIFO on the CDB; load sits at 0 so it
  // can be given absolute priority.
  typedef enum logic [2:0] {
    UNIT_LOAD   = 3'd0,
    UNIT_ALU0   = 3'd1,
    UNIT_ALU1   = 3'd2,
    UNIT_MULDIV = 3'd3,
    UNIT_BRANCH = 3'd4,
    UNIT_FPU    = 3'd5,
    UNIT_CSR    = 3'd6,
    UNIT_STORE  = 3'd7
  } unit_id_e;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_e;

  typedef struct packed {
    alu_op_e                   op;
    logic [CDB_XLEN_DEF-1:0]   a;
    logic [CDB_XLEN_DEF-1:0]   b;
    logic [CDB_TAG_W_DEF-1:0]  tag;
  } alu_in_t;

  typedef struct packed {
    logic [CDB_XLEN_DEF-1:0]   result;
    logic [CDB_TAG_W_DEF-1:0]  tag;
  } alu_out_t;

  typedef struct packed {
    logic                      valid;
    logic [CDB_TAG_W_DEF-1:0]  tag;
    logic [CDB_XLEN_DEF-1:0]   value;
  } cdb_bcast_t;

  // Round-robin successor of a granted index among n requesters.
  function automatic int rr_next(input int idx, input int n);
    return ((idx + 32'sd1) >= n) ? 32'sd0 : (idx + 32'sd1);
  endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Functional-unit side of the common data bus: per-unit FIFO heads in,
// pop strobes and the registered broadcast out.
interface cdb_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int XLEN    = 32,
  parameter int TAG_W   = `ROB_SIZE
) ();

  logic                            stall_i;
  logic                            flush_i;
  logic [NUM_REQ-1:0]              req_i;
  logic [NUM_REQ-1:0][TAG_W-1:0]   tag_i;
  logic [NUM_REQ-1:0][XLEN-1:0]    value_i;
  logic [NUM_REQ-1:0]              grant_o;
  logic                            cdb_valid_o;
  logic [TAG_W-1:0]                cdb_tag_o;
  logic [XLEN-1:0]                 cdb_value_o;

  modport master (
    output stall_i, flush_i, req_i, tag_i, value_i,
    input  grant_o, cdb_valid_o, cdb_tag_o, cdb_value_o
  );

  modport slave (
    input  stall_i, flush_i, req_i, tag_i, value_i,
    output grant_o, cdb_valid_o, cdb_tag_o, cdb_value_o
  );

endinterface

// File: rtl/cdb_arbiter_rr_pick.sv
// rr_pick: combinational masked priority picker. Returns the first request at or
// above ptr_i, wrapping to the lowest request when none lies above.
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     grant_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  logic [N-1:0]     hi_mask_s;
  logic [N-1:0]     masked_s;
  logic [IDX_W-1:0] m_idx_s;
  logic [IDX_W-1:0] a_idx_s;
  logic             m_hit_s;
  logic             a_hit_s;

  // Downward scan leaves the lowest set index of both the masked and raw vectors.
  always_comb begin
    hi_mask_s = '0;
    m_idx_s   = '0;
    a_idx_s   = '0;
    m_hit_s   = 1'b0;
    a_hit_s   = 1'b0;
    for (int i = 0; i < N; i++) begin
      hi_mask_s[i] = (i >= int'(ptr_i));
    end
    masked_s = req_i & hi_mask_s;
    for (int i = N - 1; i >= 0; i--) begin
      m_idx_s = masked_s[i] ? IDX_W'(i) : m_idx_s;
      a_idx_s = req_i[i]    ? IDX_W'(i) : a_idx_s;
      m_hit_s = m_hit_s | masked_s[i];
      a_hit_s = a_hit_s | req_i[i];
    end
    idx_o   = m_hit_s ? m_idx_s : a_idx_s;
    valid_o = a_hit_s;
    grant_o = a_hit_s ? (N'(1) << idx_o) : '0;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter for the common data bus: combinational one-hot pop grant,
// one-cycle registered broadcast. Define CDB_PRIO0_EN to give unit 0 absolute priority.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_REQ = CDB_NUM_REQ_DEF,
  parameter int XLEN    = CDB_XLEN_DEF,
  parameter int TAG_W   = `ROB_SIZE
) (
  input  logic           clk,
  input  logic           rst,
  cdb_arbiter_if.slave   bus
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0]   ptr_q,   ptr_d;
  logic               valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q,   tag_d;
  logic [XLEN-1:0]    value_q, value_d;

  logic [NUM_REQ-1:0] pick_req_s;
  logic [NUM_REQ-1:0] rr_grant_s;
  logic [IDX_W-1:0]   rr_idx_s;
  logic               rr_valid_s;
  logic [NUM_REQ-1:0] sel_grant_s;
  logic [IDX_W-1:0]   sel_idx_s;
  logic               sel_valid_s;
  logic               prio0_s;
  logic               granted_s;

`ifdef CDB_PRIO0_EN
  assign pick_req_s = bus.req_i & ~NUM_REQ'(1);
`else
  assign pick_req_s = bus.req_i;
`endif

  rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req_i   (pick_req_s),
    .ptr_i   (ptr_q),
    .grant_o (rr_grant_s),
    .idx_o   (rr_idx_s),
    .valid_o (rr_valid_s)
  );

  // Candidate selection, then gating: no pop during reset, stall or flush.
  always_comb begin
    sel_grant_s = rr_grant_s;
    sel_idx_s   = rr_idx_s;
    sel_valid_s = rr_valid_s;
    prio0_s     = 1'b0;
`ifdef CDB_PRIO0_EN
    prio0_s     = bus.req_i[0];
    sel_grant_s = prio0_s ? NUM_REQ'(1) : rr_grant_s;
    sel_idx_s   = prio0_s ? '0 : rr_idx_s;
    sel_valid_s = prio0_s | rr_valid_s;
`endif
    granted_s   = rst & ~bus.stall_i & ~bus.flush_i & sel_valid_s;
    bus.grant_o = granted_s ? sel_grant_s : '0;
  end

  // Next broadcast and pointer; flush beats stall, idle cycles keep tag/value.
  always_comb begin
    ptr_d   = ptr_q;
    valid_d = valid_q;
    tag_d   = tag_q;
    value_d = value_q;
    if (bus.flush_i) begin
      valid_d = 1'b0;
    end else if (bus.stall_i) begin
      valid_d = valid_q;
    end else if (granted_s) begin
      valid_d = 1'b1;
      tag_d   = bus.tag_i[sel_idx_s];
      value_d = bus.value_i[sel_idx_s];
      ptr_d   = prio0_s ? ptr_q : IDX_W'(rr_next(int'(sel_idx_s), NUM_REQ));
    end else begin
      valid_d = 1'b0;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_q   <= '0;
      valid_q <= 1'b0;
      tag_q   <= '0;
      value_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
      tag_q   <= tag_d;
      value_q <= value_d;
    end
  end

  assign bus.cdb_valid_o = valid_q;
  assign bus.cdb_tag_o   = tag_q;
  assign bus.cdb_value_o = value_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed sequences with literal expectations, then random
// traffic checked every cycle against a behavioural round-robin model.
module tb_cdb_arbiter;

  localparam int N  = 4;
  localparam int XL = 32;
  localparam int TW = 6;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  cdb_arbiter_if #(.NUM_REQ(N), .XLEN(XL), .TAG_W(TW)) bus ();

  cdb_arbiter #(.NUM_REQ(N), .XLEN(XL), .TAG_W(TW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  int            m_ptr   = 0;
  logic          m_valid = 1'b0;
  logic [TW-1:0] m_tag   = '0;
  logic [XL-1:0] m_value = '0;

  function automatic logic [N-1:0] model_grant(input logic r, input logic s, input logic f,
                                               input logic [N-1:0] rq, input int p);
    logic [N-1:0] g;
    int idx;
    g = '0;
    if (r && !s && !f) begin
`ifdef CDB_PRIO0_EN
      if (rq[0]) return 4'b0001;
`endif
      for (int k = 0; k < N; k++) begin
        idx = (p + k) % N;
`ifdef CDB_PRIO0_EN
        if (idx != 0 && rq[idx]) begin g[idx] = 1'b1; return g; end
`else
        if (rq[idx]) begin g[idx] = 1'b1; return g; end
`endif
      end
    end
    return g;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // One clock: drive at negedge, check grant, advance the model at posedge, check CDB.
  task automatic step(input logic r, input logic s, input logic f, input logic [N-1:0] rq,
                      input int exp_g, input int exp_v);
    logic [N-1:0]  g;
    logic [TW-1:0] tg [N];
    logic [XL-1:0] vl [N];
    int gi;
    @(negedge clk);
    rst          = r;
    bus.stall_i  = s;
    bus.flush_i  = f;
    bus.req_i    = rq;
    for (int k = 0; k < N; k++) begin
      tg[k] = TW'($urandom);
      vl[k] = $urandom;
      bus.tag_i[k]   = tg[k];
      bus.value_i[k] = vl[k];
    end
    #1;
    g = model_grant(r, s, f, rq, m_ptr);
    chk("grant", 64'(bus.grant_o), 64'(g));
    if (exp_g >= 0) chk("grant_lit", 64'(bus.grant_o), 64'(exp_g));
    gi = -1;
    for (int k = 0; k < N; k++) if (g[k]) gi = k;
    @(posedge clk);
    if (!r) begin
      m_ptr = 0; m_valid = 1'b0; m_tag = '0; m_value = '0;
    end else if (f) begin
      m_valid = 1'b0;
    end else if (s) begin
      m_valid = m_valid;
    end else if (gi >= 0) begin
      m_valid = 1'b1;
      m_tag   = tg[gi];
      m_value = vl[gi];
`ifdef CDB_PRIO0_EN
      if (gi != 0) m_ptr = (gi + 1) % N;
`else
      m_ptr = (gi + 1) % N;
`endif
    end else begin
      m_valid = 1'b0;
    end
    #1;
    chk("cdb_valid", 64'(bus.cdb_valid_o), 64'(m_valid));
    chk("cdb_tag",   64'(bus.cdb_tag_o),   64'(m_tag));
    chk("cdb_value", 64'(bus.cdb_value_o), 64'(m_value));
    if (exp_v >= 0) chk("valid_lit", 64'(bus.cdb_valid_o), 64'(exp_v));
  endtask

  initial begin
    rst         = 1'b0;
    bus.stall_i = 1'b0;
    bus.flush_i = 1'b0;
    bus.req_i   = '0;
    bus.tag_i   = '0;
    bus.value_i = '0;

    step(1'b0, 1'b0, 1'b0, 4'hF, 0, 0);
    step(1'b0, 1'b0, 1'b0, 4'hF, 0, 0);

`ifdef CDB_PRIO0_EN
    step(1'b1, 1'b0, 1'b0, 4'b0111, 1, 1);
    step(1'b1, 1'b0, 1'b0, 4'b0111, 1, 1);
    step(1'b1, 1'b0, 1'b0, 4'b0111, 1, 1);
    step(1'b1, 1'b0, 1'b0, 4'b0110, 2, 1);
    step(1'b1, 1'b0, 1'b0, 4'b0110, 4, 1);
`else
    // Reset release, full round of requests.
    step(1'b1, 1'b0, 1'b0, 4'hF, 1, 1);
    step(1'b1, 1'b0, 1'b0, 4'hF, 2, 1);
    step(1'b1, 1'b0, 1'b0, 4'hF, 4, 1);
    step(1'b1, 1'b0, 1'b0, 4'hF, 8, 1);
    step(1'b1, 1'b0, 1'b0, 4'hF, 1, 1);
    // Mid-stream reset returns the pointer to 0.
    step(1'b0, 1'b0, 1'b0, 4'hF, 0, 0);
    step(1'b1, 1'b0, 1'b0, 4'hF, 1, 1);
    // Sparse requests from pointer 0.
    step(1'b0, 1'b0, 1'b0, 4'b1010, 0, 0);
    step(1'b1, 1'b0, 1'b0, 4'b1010, 2, 1);
    step(1'b1, 1'b0, 1'b0, 4'b1010, 8, 1);
    step(1'b1, 1'b0, 1'b0, 4'b1010, 2, 1);
    // Three-cycle stall, then resume from pointer 2.
    step(1'b1, 1'b1, 1'b0, 4'hF, 0, 1);
    step(1'b1, 1'b1, 1'b0, 4'hF, 0, 1);
    step(1'b1, 1'b1, 1'b0, 4'hF, 0, 1);
    step(1'b1, 1'b0, 1'b0, 4'hF, 4, 1);
    // Flush with stall and a valid broadcast.
    step(1'b1, 1'b1, 1'b1, 4'hF, 0, 0);
    step(1'b1, 1'b0, 1'b0, 4'hF, 8, 1);
`endif

    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 49) != 0), ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 7) == 0), N'($urandom), -1, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of functional-unit result FIFOs sharing the CDB (range 2..8).
REQ-002 SHALL have parameter XLEN, default 32, result value width.
REQ-003 SHALL have parameter TAG_W, default `ROB_SIZE, ROB tag width.
REQ-004 SHALL have one clock and a synchronous active-low reset: clk in 1 (sole clock), rst in 1 (active-low, sampled on rising clk).
REQ-005 SHALL have stall_i in 1, global pipeline stall.
REQ-006 SHALL have flush_i in 1, mispredict squash.
REQ-007 SHALL have req_i in NUM_REQ, per-unit result available (unit FIFO not empty).
REQ-008 SHALL have tag_i in NUM_REQ x TAG_W, head tag of each unit FIFO.
REQ-009 SHALL have value_i in NUM_REQ x XLEN, head value of each unit FIFO.
REQ-010 SHALL have grant_o out NUM_REQ, one-hot pop strobe, drives each unit's cdb_en.
REQ-011 SHALL have cdb_valid_o out 1, CDB broadcast valid.
REQ-012 SHALL have cdb_tag_o out TAG_W, broadcast tag.
REQ-013 SHALL have cdb_value_o out XLEN, broadcast value.

Function
REQ-014 SHALL assert at most one grant_o bit per cycle; grant_o is combinational from req_i, the RR pointer and stall_i/flush_i.
REQ-015 SHALL grant the first requester at or after the RR pointer, searching upward with wrap from NUM_REQ-1 to 0.
REQ-016 SHALL set the RR pointer to (granted index + 1) mod NUM_REQ on the rising clk after a grant; the pointer SHALL hold when nothing is granted.
REQ-017 SHALL drive grant_o to all zeros while stall_i=1 or flush_i=1; the pointer SHALL hold.
REQ-018 SHALL register the granted tag_i/value_i into cdb_tag_o/cdb_value_o and set cdb_valid_o=1 on the next rising clk (one-cycle latency, grant to broadcast).
REQ-019 SHALL clear cdb_valid_o on the next clk when unstalled with no grant; cdb_tag_o/cdb_value_o SHALL then hold their last values.
REQ-020 SHALL hold cdb_valid_o/cdb_tag_o/cdb_value_o unchanged while stall_i=1 and flush_i=0.
REQ-021 SHALL clear cdb_valid_o on the next clk when flush_i=1, regardless of stall_i (flush beats stall).
REQ-022 SHALL keep the grant combinational with a registered broadcast, so that back-to-back grants give one broadcast per cycle with no bubble.
REQ-023 SHALL ignore tag_i/value_i of non-granted units.

Reset
REQ-024 SHALL, while rst=0 at a clk edge, set the RR pointer=0, cdb_valid_o=0, cdb_tag_o=0 and cdb_value_o=0.
REQ-025 SHALL force grant_o=0 while rst=0, so that no FIFO pops during reset, including when reset is asserted mid-stream.
REQ-026 SHALL grant on the first clk after rst returns to 1, starting the search at index 0.

Configuration
REQ-027 SHALL, when macro CDB_PRIO0_EN is defined, give requester 0 (load unit) absolute priority over all others; RR SHALL then apply among indices 1..NUM_REQ-1 only, and a grant to 0 SHALL NOT move the pointer.
REQ-028 SHALL, when CDB_PRIO0_EN is undefined, treat all NUM_REQ requesters under pure round-robin per REQ-015/016.

Structure
REQ-029 SHALL define the CDB broadcast struct (valid, tag, value) in the shared package next to alu_in/alu_out, together with NUM_REQ's default constant; the unit-ID encoding SHALL also live in the package.
REQ-030 SHALL split out one sub-module, rr_pick, a combinational masked priority picker (req, pointer -> one-hot grant, index), which is reused by the issue scheduler.

Verification
REQ-031 SHALL cover: reset release with req_i=4'b1111 -> grant_o 0001, 0010, 0100, 1000, 0001 on successive cycles, each broadcast one cycle later with matching tag.
REQ-032 SHALL cover: req_i=4'b1010, pointer=0 -> grant_o=0010, then 1000, then 0010; no wasted cycles.
REQ-033 SHALL cover: stall_i=1 for 3 cycles with pending requests -> grant_o=0, CDB outputs frozen, pointer unchanged; resume continues the sequence.
REQ-034 SHALL cover: flush_i=1 with stall_i=1 and cdb_valid_o=1 -> cdb_valid_o=0 next cycle, grant_o=0 during the flush.
REQ-035 SHALL cover: rst=0 asserted mid-stream with req_i=4'b1111 -> grant_o=0 immediately, cdb_valid_o=0 next clk, pointer=0.
REQ-036 SHALL cover: with CDB_PRIO0_EN, req_i=4'b0111 held -> unit 0 granted every cycle; drop req 0 -> 0010 then 0100.
